// File: rtl/reg_file_n.sv
// Parametrised register bank: one write port, two registered read ports with
// write-to-read bypass, and a per-register busy scoreboard.
// Optional macro REG_FILE_R0_ZERO_EN hardwires register 0 (and busy[0]) to zero.
module reg_file_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       ra_addr,
  input  logic [AW-1:0]       rb_addr,
  output logic [WIDTH-1:0]    ra_data,
  output logic [WIDTH-1:0]    rb_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                ra_busy,
  output logic                rb_busy,
  output logic [(2**AW)-1:0]  busy_vec
);

  localparam int unsigned DEPTH = 2**AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] ra_data_q, ra_data_d;
  logic [WIDTH-1:0] rb_data_q, rb_data_d;
  logic             ra_busy_q, ra_busy_d;
  logic             rb_busy_q, rb_busy_d;
  logic             wr_ok;
  logic             rsv_ok;

  // Next state: write and scoreboard update first, then read ports sample the result.
  always_comb begin
    mem_d     = mem_q;
    busy_d    = busy_q;
    ra_data_d = ra_data_q;
    rb_data_d = rb_data_q;
    ra_busy_d = ra_busy_q;
    rb_busy_d = rb_busy_q;
`ifdef REG_FILE_R0_ZERO_EN
    wr_ok  = wr_en  && (wr_addr  != '0);
    rsv_ok = rsv_en && (rsv_addr != '0);
`else
    wr_ok  = wr_en;
    rsv_ok = rsv_en;
`endif

    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // A reservation in the same cycle as a write to the same register wins.
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
`ifdef REG_FILE_R0_ZERO_EN
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
`endif

    if (rd_en) begin
      ra_data_d = (wr_ok && (wr_addr == ra_addr)) ? wr_data : mem_q[ra_addr];
      rb_data_d = (wr_ok && (wr_addr == rb_addr)) ? wr_data : mem_q[rb_addr];
      ra_busy_d = busy_d[ra_addr];
      rb_busy_d = busy_d[rb_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      ra_data_q <= '0;
      rb_data_q <= '0;
      ra_busy_q <= 1'b0;
      rb_busy_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      busy_q    <= busy_d;
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
      ra_busy_q <= ra_busy_d;
      rb_busy_q <= rb_busy_d;
    end
  end

  assign ra_data  = ra_data_q;
  assign rb_data  = rb_data_q;
  assign ra_busy  = ra_busy_q;
  assign rb_busy  = rb_busy_q;
  assign busy_vec = busy_q;

endmodule

// File: doc/reg_file_n.md
Name: reg_file_n

Overview:
- Parametrised register bank; successor to the single 32-bit enable/clear register.
- Holds 2**AW words of WIDTH bits.
- One write port, two registered read ports (A/B) with write-to-read bypass.
- Per-register busy scoreboard so the datapath control unit can detect pending writes.
- Sits in the CPU datapath between the bus/ALU result and the operand latches.

Parameters:
- WIDTH, 32, data width of each register.
- AW, 4, address width; register count DEPTH = 2**AW.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-low reset; sampled on rising clk.
- wr_en  input  1  write strobe.
- wr_addr  input  AW  write register index.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read strobe; updates both read outputs.
- ra_addr  input  AW  read port A index.
- rb_addr  input  AW  read port B index.
- ra_data  output  WIDTH  port A data, registered.
- rb_data  output  WIDTH  port B data, registered.
- rsv_en  input  1  reserve strobe; marks rsv_addr busy.
- rsv_addr  input  AW  register to reserve.
- ra_busy  output  1  busy bit of ra_addr, registered alongside ra_data.
- rb_busy  output  1  busy bit of rb_addr, registered alongside rb_data.
- busy_vec  output  2**AW  live scoreboard, bit i = register i busy.

Behaviour:
- Reset:
  - clr low at a rising edge forces every register, ra_data, rb_data, ra_busy, rb_busy and busy_vec to 0.
  - Overrides wr_en, rd_en and rsv_en in the same cycle.
  - Reset mid-operation discards any pending reservation or write.
- Write: wr_en high at edge N → mem[wr_addr] = wr_data after edge N. wr_en low → contents hold.
- Read:
  - rd_en high at edge N → ra_data/rb_data present the addressed words after edge N (1-cycle latency).
  - rd_en low → ra_data, rb_data, ra_busy, rb_busy hold their previous values.
- Bypass:
  - rd_en and wr_en both high at edge N with ra_addr == wr_addr → ra_data = wr_data, not the stale word. Same rule for port B.
  - Both ports may hit the same address; both receive the bypassed value.
- Scoreboard:
  - rsv_en at edge N sets busy[rsv_addr].
  - wr_en at edge N clears busy[wr_addr].
  - rsv_en and wr_en to the same address in the same cycle → busy stays set; the new reservation wins.
  - rsv_en and wr_en to different addresses → both take effect.
  - Reserving an already-busy register leaves it busy; no error.
- Read-port busy:
  - ra_busy/rb_busy reflect the scoreboard value that takes effect at the same edge as the read.
  - Write-clear and reserve-set are applied before sampling, consistent with the bypass rule.
- busy_vec is a direct register output, updated each edge.
- Address range is always in bounds (DEPTH = 2**AW); no wrap handling is required.

Optional Feature:
- Macro: REG_FILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0; writes to address 0 are ignored.
  - Reads of address 0 return 0, including the bypass path.
  - rsv_en to address 0 is ignored; busy[0] is constant 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- clr low one cycle after arbitrary writes → next read of addresses 0..15 returns 0x00000000; busy_vec == 0.
- Write 0xDEADBEEF to r5; next cycle rd_en with ra_addr=5, rb_addr=5 → after one edge ra_data == rb_data == 0xDEADBEEF.
- r3 holds 0x11111111; same cycle wr_en r3=0x22222222, rd_en ra_addr=3 → ra_data == 0x22222222 after that edge.
- rsv_en r7 → busy_vec[7]=1. Write r7=0x0000ABCD → busy_vec[7]=0. Simultaneous rsv_en r7 + wr_en r7 → busy_vec[7]=1 and r7 updated.
- rd_en low while writing ra_addr's register → ra_data holds its old value until the next rd_en.
- With REG_FILE_R0_ZERO_EN: write r0=0xFFFFFFFF and rsv r0, then read r0 → ra_data == 0, busy_vec[0] == 0. Without the macro: ra_data == 0xFFFFFFFF.
